// File: rtl/gate_exhaustive_checker.sv
// rtl/gate_exhaustive_checker.sv - exhaustive truth-table checker for a combinational gate
module gate_exhaustive_checker #(
    parameter int                          N_INPUTS      = 2,
    parameter int                          SETTLE_CYCLES = 1,
    parameter logic [(2**N_INPUTS)-1:0]    EXPECT_TT     = 4'b1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  dut_out,
    output logic [N_INPUTS-1:0]   dut_in,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [N_INPUTS:0]     err_count,
    output logic                  fail_valid,
    output logic [N_INPUTS-1:0]   fail_vector
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0]       SETTLE_INIT = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0]       CNT_ONE     = CW'(1);
    localparam logic [N_INPUTS-1:0] LAST_VEC    = '1;
    localparam logic [N_INPUTS-1:0] VEC_ONE     = N_INPUTS'(1);
    localparam logic [N_INPUTS:0]   ERR_ONE     = (N_INPUTS + 1)'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [N_INPUTS-1:0]   vec;
    logic [CW-1:0]         settle_cnt;
    logic                  mismatch;

    // Compare against the table entry of the vector in flight; dut_in equals vec here.
    assign mismatch = (dut_out != EXPECT_TT[vec]);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                state_next = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt == '0) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                if (vec == LAST_VEC) begin
                    state_next = DONE;
                end else begin
                    state_next = DRIVE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec         <= '0;
            settle_cnt  <= '0;
            dut_in      <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_count   <= '0;
            fail_valid  <= 1'b0;
            fail_vector <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Results stay frozen until a new run is accepted.
                    if (start) begin
                        vec         <= '0;
                        err_count   <= '0;
                        fail_valid  <= 1'b0;
                        fail_vector <= '0;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                    end
                end
                DRIVE: begin
                    dut_in     <= vec;
                    settle_cnt <= SETTLE_INIT;
                end
                SETTLE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - CNT_ONE;
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        err_count <= err_count + ERR_ONE;
                        if (!fail_valid) begin
                            fail_vector <= vec;
                            fail_valid  <= 1'b1;
                        end
                    end
                    // The last vector exits to DONE, so vec never wraps inside a run.
                    if (vec != LAST_VEC) begin
                        vec <= vec + VEC_ONE;
                    end
                end
                DONE: begin
                    done <= 1'b1;
                    pass <= (err_count == '0);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_exhaustive_checker.sv
// tb/tb_gate_exhaustive_checker.sv - scoreboard bench for gate_exhaustive_checker
module tb_gate_exhaustive_checker;

    typedef struct {
        int errs;
        int fv;
        int fvalid;
        int pass;
        int cycles;
        int nvec;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [3:0] fault_tt_a = 4'b1000;
    logic [7:0] fault_tt_b = 8'h96;

    logic       dut_out_a;
    logic [1:0] dut_in_a;
    logic       busy_a, done_a, pass_a, fail_valid_a;
    logic [2:0] err_count_a;
    logic [1:0] fail_vector_a;

    logic       dut_out_b;
    logic [2:0] dut_in_b;
    logic       busy_b, done_b, pass_b, fail_valid_b;
    logic [3:0] err_count_b;
    logic [2:0] fail_vector_b;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t sb_a[$];
    exp_t sb_b[$];
    int   walk_a[$];
    int   walk_b[$];
    int   cyc_a = 0, cyc_b = 0;
    bit   prev_busy_a = 0, prev_done_a = 0, prev_busy_b = 0, prev_done_b = 0;

    always #5 clk = ~clk;

    // The gate under test is modelled as a lookup table so faults can be planted freely.
    assign dut_out_a = fault_tt_a[dut_in_a];
    assign dut_out_b = fault_tt_b[dut_in_b];

    gate_exhaustive_checker u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .dut_out(dut_out_a),
        .dut_in(dut_in_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_count_a), .fail_valid(fail_valid_a), .fail_vector(fail_vector_a)
    );

    gate_exhaustive_checker #(
        .N_INPUTS(3), .SETTLE_CYCLES(3), .EXPECT_TT(8'h96)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .dut_out(dut_out_b),
        .dut_in(dut_in_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_count_b), .fail_valid(fail_valid_b), .fail_vector(fail_vector_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: count table disagreements over every vector, note the lowest one.
    function automatic exp_t model(input int n, input int settle, input logic [63:0] tt,
                                   input logic [63:0] gate);
        exp_t e;
        e.errs = 0;
        e.fv = 0;
        e.fvalid = 0;
        e.nvec = 1 << n;
        for (int v = 0; v < e.nvec; v++) begin
            if (tt[v] != gate[v]) begin
                if (e.errs == 0) begin
                    e.fv = v;
                    e.fvalid = 1;
                end
                e.errs++;
            end
        end
        e.pass = (e.errs == 0) ? 1 : 0;
        e.cycles = e.nvec * (settle + 2) + 1;
        return e;
    endfunction

    task automatic compare_run(input string tag, input exp_t e, input int errc, input int fv,
                               input int fval, input int ps, input int cyc, input int wlen,
                               input int wok);
        chk({tag, " err_count"}, errc, e.errs);
        chk({tag, " fail_vector"}, fv, e.fv);
        chk({tag, " fail_valid"}, fval, e.fvalid);
        chk({tag, " pass"}, ps, e.pass);
        chk({tag, " busy_cycles"}, cyc, e.cycles);
        chk({tag, " walk_len"}, wlen, e.nvec);
        chk({tag, " walk_order"}, wok, 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        int ok;
        if (busy_a && !prev_busy_a) begin
            cyc_a = 0;
            walk_a.delete();
        end
        if (busy_a) begin
            cyc_a++;
            if (prev_busy_a && (walk_a.size() == 0 || walk_a[$] != int'(dut_in_a)))
                walk_a.push_back(int'(dut_in_a));
        end
        if (done_a && !prev_done_a) begin
            if (sb_a.size() == 0) begin
                chk("A unexpected done", 1, 0);
            end else begin
                e = sb_a.pop_front();
                ok = 1;
                foreach (walk_a[i]) if (walk_a[i] != i) ok = 0;
                compare_run("A", e, int'(err_count_a), int'(fail_vector_a), int'(fail_valid_a),
                            int'(pass_a), cyc_a, walk_a.size(), ok);
            end
        end
        prev_busy_a = busy_a;
        prev_done_a = done_a;
    end

    always @(negedge clk) begin
        exp_t e;
        int ok;
        if (busy_b && !prev_busy_b) begin
            cyc_b = 0;
            walk_b.delete();
        end
        if (busy_b) begin
            cyc_b++;
            if (prev_busy_b && (walk_b.size() == 0 || walk_b[$] != int'(dut_in_b)))
                walk_b.push_back(int'(dut_in_b));
        end
        if (done_b && !prev_done_b) begin
            if (sb_b.size() == 0) begin
                chk("B unexpected done", 1, 0);
            end else begin
                e = sb_b.pop_front();
                ok = 1;
                foreach (walk_b[i]) if (walk_b[i] != i) ok = 0;
                compare_run("B", e, int'(err_count_b), int'(fail_vector_b), int'(fail_valid_b),
                            int'(pass_b), cyc_b, walk_b.size(), ok);
            end
        end
        prev_busy_b = busy_b;
        prev_done_b = done_b;
    end

    task automatic run_a(input logic [3:0] gate, input bit poke);
        bit seen;
        fault_tt_a = gate;
        sb_a.push_back(model(2, 1, 64'(4'b1000), 64'(gate)));
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            start_a = (poke && i == 5) ? 1'b1 : 1'b0;
            if (done_a) seen = 1;
        end
        start_a = 1'b0;
        if (!seen) chk("A run timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic run_b(input logic [7:0] gate);
        bit seen;
        fault_tt_b = gate;
        sb_b.push_back(model(3, 3, 64'(8'h96), 64'(gate)));
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        chk("B done cleared on accept", int'(done_b), 0);
        chk("B busy after accept", int'(busy_b), 1);
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (done_b) seen = 1;
        end
        if (!seen) chk("B run timeout", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] m4;
        logic [7:0] m8;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset dut_in", int'(dut_in_a), 0);
        chk("reset busy", int'(busy_a), 0);
        chk("reset done", int'(done_a), 0);
        chk("reset pass", int'(pass_a), 0);
        chk("reset err_count", int'(err_count_a), 0);
        chk("reset fail_valid", int'(fail_valid_a), 0);
        chk("reset fail_vector", int'(fail_vector_a), 0);

        run_a(4'b1000, 0);
        run_a(4'b0000, 0);
        run_a(4'b0111, 0);
        chk("A results held in idle", int'(err_count_a), 4);
        run_a(4'b1000, 1);

        // Abort in SETTLE of vector 1, then confirm a clean rerun.
        fault_tt_a = 4'b0000;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort in settle v1 dut_in", int'(dut_in_a), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort busy", int'(busy_a), 0);
        chk("abort done", int'(done_a), 0);
        chk("abort dut_in", int'(dut_in_a), 0);
        chk("abort err_count", int'(err_count_a), 0);
        chk("abort fail_valid", int'(fail_valid_a), 0);
        chk("abort fail_vector", int'(fail_vector_a), 0);
        run_a(4'b1000, 0);

        for (int r = 0; r < 6; r++) begin
            m4 = 4'($urandom);
            if (r == 0) m4 = 4'b0000;
            run_a(4'b1000 ^ m4, ($urandom_range(0, 1) == 1));
        end

        run_b(8'h96);
        run_b(8'h96);
        for (int r = 0; r < 3; r++) begin
            m8 = 8'($urandom);
            run_b(8'h96 ^ m8);
        end

        chk("A scoreboard drained", sb_a.size(), 0);
        chk("B scoreboard drained", sb_b.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
